// File: rtl/core_mem_mp.sv
// Multi-port core memory controller: round-robin grant, destructive read with restore/RMW write-back.
// Optional CORE_SINGLE_STEP_EN: single-step STOP after RECOVER, left on a rising edge of sw_restart.
//
// state   | meaning
// IDLE    | sample port requests, grant round-robin
// ACK     | one-clock address acknowledge to the granted port
// READ    | T_RD access clocks, destructive read on the last; optional rd_rs clock after
// PAUSE   | RMW wait for wr_rs (new data) or dropped rq_cyc (abort, restore)
// WRITE   | T_WR access clocks, write cmb back on the last
// RECOVER | one-clock recovery before IDLE
// STOP    | single-step halt (only with CORE_SINGLE_STEP_EN)
module core_mem_mp #(
    parameter int                    NPORTS = 4,
    parameter int                    AW     = 14,
    parameter int                    DW     = 36,
    parameter logic [4*NPORTS-1:0]   SEL    = {NPORTS{4'b0000}},
    parameter int                    T_RD   = 4,
    parameter int                    T_WR   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NPORTS-1:0]      membus_rq_cyc,
    input  logic [NPORTS-1:0]      membus_rd_rq,
    input  logic [NPORTS-1:0]      membus_wr_rq,
    input  logic [NPORTS-1:0]      membus_wr_rs,
    input  logic [NPORTS-1:0]      membus_fmc_select,
    input  logic [4*NPORTS-1:0]    membus_sel,
    input  logic [AW*NPORTS-1:0]   membus_ma,
    input  logic [DW*NPORTS-1:0]   membus_mb_in,
    output logic [NPORTS-1:0]      membus_addr_ack,
    output logic [NPORTS-1:0]      membus_rd_rs,
    output logic [DW*NPORTS-1:0]   membus_mb_out,
    input  logic                   sw_single_step,
    input  logic                   sw_restart,
    output logic                   cmc_busy
);

    localparam int GW   = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int TMAX = (T_RD > T_WR) ? T_RD : T_WR;
    localparam int CW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, ACK, READ, PAUSE, WRITE, RECOVER, STOP} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   g, last_grant, grant_idx, cand;
    logic [AW-1:0]   cma;
    logic [DW-1:0]   cmb, save;
    logic            rd_flag, wr_flag, rs_phase;
    logic [CW-1:0]   cnt;
    logic            tc, any_req, mem_we;
    logic [NPORTS-1:0] req;
    logic [DW-1:0]   core [2**AW];

    assign tc      = (cnt == '0);
    assign any_req = |req;

    // Candidates are scanned from farthest to nearest so the nearest requester wins.
    always_comb begin
        req       = '0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NPORTS; i++) begin
            req[i] = membus_rq_cyc[i] & (membus_sel[4*i +: 4] == SEL[4*i +: 4])
                     & ~membus_fmc_select[i];
        end
        for (int k = NPORTS; k >= 1; k--) begin
            cand = GW'((int'(last_grant) + k) % NPORTS);
            if (req[cand]) grant_idx = cand;
        end
    end

`ifdef CORE_SINGLE_STEP_EN
    logic sw_restart_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sw_restart_q <= 1'b0;
        else        sw_restart_q <= sw_restart;
    end
`else
    logic unused_sw;
    assign unused_sw = sw_single_step ^ sw_restart;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACK;
            ACK:     state_nxt = READ;
            READ:    if (rs_phase || (tc && !rd_flag)) state_nxt = wr_flag ? PAUSE : WRITE;
            PAUSE:   if (membus_wr_rs[g] || !membus_rq_cyc[g]) state_nxt = WRITE;
            WRITE:   if (tc) state_nxt = RECOVER;
`ifdef CORE_SINGLE_STEP_EN
            RECOVER: state_nxt = sw_single_step ? STOP : IDLE;
            STOP:    if (sw_restart && !sw_restart_q) state_nxt = IDLE;
`else
            RECOVER: state_nxt = IDLE;
            STOP:    state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        membus_addr_ack = '0;
        membus_rd_rs    = '0;
        membus_mb_out   = '0;
        if (state == ACK) membus_addr_ack[g] = 1'b1;
        if (state == READ && rs_phase) begin
            membus_rd_rs[g]                  = 1'b1;
            membus_mb_out[int'(g)*DW +: DW]  = cmb;
        end
    end

    assign cmc_busy = (state != IDLE) && (state != STOP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            g          <= '0;
            last_grant <= GW'(NPORTS - 1);
            cma        <= '0;
            cmb        <= '0;
            save       <= '0;
            rd_flag    <= 1'b0;
            wr_flag    <= 1'b0;
            rs_phase   <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    g          <= grant_idx;
                    last_grant <= grant_idx;
                    cma        <= membus_ma[int'(grant_idx)*AW +: AW];
                    rd_flag    <= membus_rd_rq[grant_idx];
                    wr_flag    <= membus_wr_rq[grant_idx];
                end
                ACK: begin
                    cnt      <= CW'(T_RD - 1);
                    rs_phase <= 1'b0;
                end
                READ: begin
                    if (rs_phase) begin
                        rs_phase <= 1'b0;
                        if (wr_flag) cmb <= '0;
                        cnt <= CW'(T_WR - 1);
                    end else if (tc) begin
                        save <= core[cma];
                        if (rd_flag) begin
                            cmb      <= core[cma];
                            rs_phase <= 1'b1;
                        end else begin
                            cmb <= wr_flag ? '0 : core[cma];
                            cnt <= CW'(T_WR - 1);
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                PAUSE: begin
                    if (membus_wr_rs[g])        cmb <= membus_mb_in[int'(g)*DW +: DW];
                    else if (!membus_rq_cyc[g]) cmb <= save;
                end
                WRITE: if (!tc) cnt <= cnt - CW'(1);
                default: ;
            endcase
        end
    end

    // Memory has no reset so its contents survive reset; the read clears the word.
    assign mem_we = (state == READ && tc && !rs_phase) || (state == WRITE && tc);

    always_ff @(posedge clk) begin
        if (mem_we) core[cma] <= (state == WRITE) ? cmb : '0;
    end

endmodule

// File: tb/tb_core_mem_mp.sv
// Directed plus randomized bench for core_mem_mp against an associative-array memory model.
module tb_core_mem_mp;
    localparam int NP = 4, AW = 14, DW = 36, T_RD = 4, T_WR = 4;

    logic clk = 1'b0, reset = 1'b0;
    logic [NP-1:0]    rq_cyc = '0, rd_rq = '0, wr_rq = '0, wr_rs = '0, fmc = '0;
    logic [4*NP-1:0]  sel = '0;
    logic [AW*NP-1:0] ma = '0;
    logic [DW*NP-1:0] mb_in = '0;
    logic [NP-1:0]    addr_ack, rd_rs;
    logic [DW*NP-1:0] mb_out;
    logic             sw_single_step = 1'b0, sw_restart = 1'b0;
    logic             cmc_busy;

    always #5 clk = ~clk;

    core_mem_mp #(.NPORTS(NP), .AW(AW), .DW(DW), .SEL({NP{4'b0000}}), .T_RD(T_RD), .T_WR(T_WR)) dut (
        .clk(clk), .reset(reset),
        .membus_rq_cyc(rq_cyc), .membus_rd_rq(rd_rq), .membus_wr_rq(wr_rq),
        .membus_wr_rs(wr_rs), .membus_fmc_select(fmc), .membus_sel(sel),
        .membus_ma(ma), .membus_mb_in(mb_in),
        .membus_addr_ack(addr_ack), .membus_rd_rs(rd_rs), .membus_mb_out(mb_out),
        .sw_single_step(sw_single_step), .sw_restart(sw_restart), .cmc_busy(cmc_busy)
    );

    int n_pass = 0, n_checks = 0;
    logic [DW-1:0] mem_m [int];
    int lg_m = NP - 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    function automatic int rr_pick(input logic [NP-1:0] m, input int lg);
        for (int k = 1; k <= NP; k++) begin
            if (((m >> ((lg + k) % NP)) & 1) != 0) return (lg + k) % NP;
        end
        return -1;
    endfunction

    function automatic logic [NP-1:0] onehot(input int p);
        logic [NP-1:0] v;
        v = '0;
        if (p >= 0) v = NP'(1) << p;
        return v;
    endfunction

    task automatic clear_inputs();
        rq_cyc = '0; rd_rq = '0; wr_rq = '0; wr_rs = '0; fmc = '0; sel = '0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 50 && cmc_busy; t++) @(negedge clk);
        check("idle_wait", {255'd0, cmc_busy}, 256'd0);
    endtask

    // One full memory cycle from a single port; expected timing follows the cycle-length rule.
    task automatic run_cycle(input int p, input int addr, input bit rd, input bit wr,
                             input logic [DW-1:0] wd, input bit abort, input int plen);
        logic [DW-1:0]    old;
        logic [NP-1:0]    exp_ack, exp_rs;
        logic [DW*NP-1:0] exp_mb;
        bit got_ack;
        int k, busy, kp;
        old = mem_m.exists(addr) ? mem_m[addr] : '0;
        rq_cyc[p] = 1'b1; rd_rq[p] = rd; wr_rq[p] = wr; wr_rs[p] = 1'b0;
        ma[p*AW +: AW] = AW'(addr); mb_in[p*DW +: DW] = wd;
        got_ack = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (addr_ack != '0) begin got_ack = 1'b1; break; end
        end
        check("ack_seen", {255'd0, got_ack}, 256'd1);
        if (!got_ack) begin clear_inputs(); return; end
        lg_m = p;
        if (!wr) rq_cyc[p] = 1'b0;
        kp = 1 + T_RD + int'(rd) + plen;
        busy = 0; k = 0;
        while (cmc_busy && k < 60) begin
            exp_ack = (k == 0) ? onehot(p) : '0;
            exp_rs  = (rd && k == T_RD + 1) ? onehot(p) : '0;
            exp_mb  = '0;
            if (exp_rs != '0) exp_mb[p*DW +: DW] = old;
            check($sformatf("lanes p%0d k%0d", p, k), {104'd0, addr_ack, rd_rs, mb_out},
                  {104'd0, exp_ack, exp_rs, exp_mb});
            busy++;
            if (wr && k == kp) begin
                if (abort) rq_cyc[p] = 1'b0;
                else       wr_rs[p]  = 1'b1;
            end
            if (wr && k == kp + 1) begin rq_cyc[p] = 1'b0; wr_rs[p] = 1'b0; end
            @(negedge clk);
            k++;
        end
        check("cycle_len", 256'(busy), 256'(1 + T_RD + int'(rd) + (wr ? plen + 1 : 0) + T_WR + 1));
        clear_inputs();
        if (wr && !abort) mem_m[addr] = wd;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int addrs[4];
        int nack;
        bit seen;
        logic [NP-1:0] mask;
        addrs = '{'o100, 'o200, 'o3000, 'o37777};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {103'd0, addr_ack, rd_rs, mb_out, cmc_busy}, 256'd0);
        reset = 1'b1;
        @(negedge clk);

        // Write-only from port 1, read twice from port 0, RMW from port 2
        run_cycle(1, 'o100, 0, 1, 36'o123456701234, 0, 0);
        run_cycle(0, 'o100, 1, 0, '0, 0, 0);
        run_cycle(0, 'o100, 1, 0, '0, 0, 0);
        run_cycle(2, 'o100, 1, 1, 36'd5, 0, 1);
        run_cycle(3, 'o100, 1, 0, '0, 0, 0);

        // RMW aborted in PAUSE leaves the word unchanged
        run_cycle(3, 'o100, 1, 1, 36'o777, 1, 2);
        run_cycle(1, 'o100, 1, 0, '0, 0, 0);

        // Reset during READ
        rq_cyc[0] = 1'b1; rd_rq[0] = 1'b1; ma[0 +: AW] = AW'('o100);
        seen = 1'b0;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(negedge clk);
            seen = (addr_ack != '0);
        end
        check("rst_ack_seen", {255'd0, seen}, 256'd1);
        clear_inputs();
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        #1 check("reset_mid_read", {103'd0, addr_ack, rd_rs, mb_out, cmc_busy}, 256'd0);
        @(negedge clk);
        reset = 1'b1;
        lg_m = NP - 1;
        @(negedge clk);

        // Round-robin between ports 0 and 3
        mask = 4'b1001;
        rq_cyc = mask; rd_rq = mask;
        ma[0 +: AW] = AW'('o100); ma[3*AW +: AW] = AW'('o100);
        nack = 0;
        for (int t = 0; t < 200 && nack < 4; t++) begin
            @(negedge clk);
            if (addr_ack != '0) begin
                check($sformatf("rr_grant%0d", nack), {252'd0, addr_ack}, {252'd0, onehot(rr_pick(mask, lg_m))});
                lg_m = rr_pick(mask, lg_m);
                nack++;
            end
        end
        check("rr_count", 256'(nack), 256'd4);
        clear_inputs();
        wait_idle();
        run_cycle(3, 'o100, 1, 0, '0, 0, 0);

        // Wrong module select and fast-memory select are ignored
        rq_cyc[1] = 1'b1; sel[4 +: 4] = 4'h5;
        rq_cyc[2] = 1'b1; fmc[2] = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (addr_ack != '0 || cmc_busy) seen = 1'b1;
        end
        check("no_ack_unselected", {255'd0, seen}, 256'd0);
        clear_inputs();

`ifdef CORE_SINGLE_STEP_EN
        sw_single_step = 1'b1;
        run_cycle(0, 'o100, 1, 0, '0, 0, 0);
        sw_single_step = 1'b0;
        rq_cyc[1] = 1'b1; rd_rq[1] = 1'b1; ma[AW +: AW] = AW'('o100);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (addr_ack != '0) seen = 1'b1;
        end
        check("stop_holds", {255'd0, seen}, 256'd0);
        sw_restart = 1'b1;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            seen = (addr_ack != '0);
        end
        check("restart_ack", {252'd0, addr_ack}, {252'd0, onehot(1)});
        lg_m = 1;
        clear_inputs();
        sw_restart = 1'b0;
        wait_idle();
`else
        sw_single_step = 1'b1; sw_restart = 1'b1;
        run_cycle(0, 'o100, 1, 0, '0, 0, 0);
        sw_restart = 1'b0;
        run_cycle(1, 'o100, 1, 0, '0, 0, 0);
        sw_single_step = 1'b0;
`endif

        // Randomized traffic against the memory model
        foreach (addrs[i]) run_cycle($urandom_range(0, NP-1), addrs[i], 0, 1, DW'({$urandom, $urandom}), 0, 0);
        repeat (16) begin
            int op, p, a;
            op = $urandom_range(0, 3);
            p  = $urandom_range(0, NP-1);
            a  = addrs[$urandom_range(0, 3)];
            case (op)
                0: run_cycle(p, a, 1, 0, '0, 0, 0);
                1: run_cycle(p, a, 0, 1, DW'({$urandom, $urandom}), 0, $urandom_range(0, 2));
                2: run_cycle(p, a, 1, 1, DW'({$urandom, $urandom}), 0, $urandom_range(0, 2));
                default: run_cycle(p, a, 1, 1, DW'({$urandom, $urandom}), 1, $urandom_range(0, 2));
            endcase
        end
        foreach (addrs[i]) run_cycle(i % NP, addrs[i], 1, 0, '0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
